// File: rtl/chk_sum_stream_if.sv
// Beat-stream and result-port bundle for the streaming ones'-complement
// checksum engine. The slave side is the engine, the master side feeds
// beats and consumes results.
interface chk_sum_stream_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    localparam int NB = DATA_W / 8;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [NB-1:0]     in_keep;
    logic              in_last;
    logic              res_valid;
    logic              res_ready;
    logic [15:0]       res_data;
    logic [LEN_W-1:0]  res_len;

    modport master (
        output in_valid, in_data, in_keep, in_last, res_ready,
        input  in_ready, res_valid, res_data, res_len
    );

    modport slave (
        input  in_valid, in_data, in_keep, in_last, res_ready,
        output in_ready, res_valid, res_data, res_len
    );
endinterface

// File: rtl/chk_sum_stream.sv
// Streaming 16-bit ones'-complement (Internet) checksum engine.
// Sums DATA_W-bit beats with per-byte keep into a folded 16-bit accumulator,
// starting each packet from a seed (pseudo-header), and hands out the
// checksum plus kept-byte count through a valid/ready result port.
module chk_sum_stream #(
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 16,
    parameter bit INVERT   = 1'b1,
    parameter bit ZERO_FIX = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    input  logic        abort,
    chk_sum_stream_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int NW    = DATA_W / 16;
    localparam int SUM_W = 16 + $clog2(NW + 1);

    // Reject unsupported beat widths at elaboration.
    if ((DATA_W % 16) != 0 || DATA_W < 16 || DATA_W > 128) begin : g_bad_width
        $error("chk_sum_stream: DATA_W must be a multiple of 16 in 16..128");
    end

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_FIN = 2'd1,
        S_OUT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       acc_q;
    logic [LEN_W-1:0]  len_q;
    logic              first_q;
    logic [15:0]       res_data_q;
    logic [LEN_W-1:0]  res_len_q;

    logic              in_ready_c;
    logic              res_valid_c;
    logic              beat_acc;
    logic [DATA_W-1:0] masked;
    logic [LEN_W-1:0]  kept_cnt;
    logic [SUM_W-1:0]  sum;
    logic [16:0]       fold1;
    logic [15:0]       fold2;
    logic [LEN_W-1:0]  len_next;
    logic [15:0]       fin_data;

    assign beat_acc = bus.in_valid && in_ready_c;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (rst) begin
            state_q <= S_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; abort overrides any beat or result handshake.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // and no latch is inferred.
        state_d = state_q;
        if (abort) begin
            state_d = S_ACC;
        end else begin
            unique case (state_q)
                S_ACC:   if (beat_acc && bus.in_last) state_d = S_FIN;
                S_FIN:   state_d = S_OUT;
                S_OUT:   if (bus.res_ready) state_d = S_ACC;
                default: state_d = S_ACC;
            endcase
        end
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        in_ready_c  = (state_q == S_ACC);
        res_valid_c = (state_q == S_OUT);
    end

    // Mask dropped lanes to zero and count the kept ones.
    always_comb begin
        masked   = '0;
        kept_cnt = '0;
        for (int i = 0; i < NB; i++) begin
            if (bus.in_keep[i]) begin
                masked[DATA_W-1-8*i -: 8] = bus.in_data[DATA_W-1-8*i -: 8];
            end
            kept_cnt = kept_cnt + LEN_W'(bus.in_keep[i]);
        end
    end

    // Wide sum of the base and all words, then two end-around-carry folds.
    // After the first fold the carry is at most NW, so the second fold can
    // never carry out again and the result always fits in 16 bits.
    always_comb begin
        sum = SUM_W'(first_q ? seed : acc_q);
        for (int k = 0; k < NW; k++) begin
            sum = sum + SUM_W'(masked[DATA_W-1-16*k -: 16]);
        end
        fold1 = {1'b0, sum[15:0]} + 17'(sum[SUM_W-1:16]);
        fold2 = fold1[15:0] + 16'(fold1[16]);
    end

    // Byte count restarts from zero on the first beat of a packet.
    assign len_next = (first_q ? '0 : len_q) + kept_cnt;

    // Final inversion, with the UDP rule mapping an all-zero checksum to 0xFFFF.
    always_comb begin
        fin_data = INVERT ? ~acc_q : acc_q;
        if (INVERT && ZERO_FIX && (fin_data == 16'h0000)) begin
            fin_data = 16'hFFFF;
        end
    end

    // Accumulator, byte count, first-beat flag and result registers.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            acc_q      <= '0;
            len_q      <= '0;
            first_q    <= 1'b1;
            res_data_q <= '0;
            res_len_q  <= '0;
        end else begin
            unique case (state_q)
                S_ACC: begin
                    if (beat_acc) begin
                        acc_q <= fold2;
                        len_q <= len_next;
                        if (!bus.in_last) begin
                            first_q <= 1'b0;
                        end
                    end
                end
                S_FIN: begin
                    res_data_q <= fin_data;
                    res_len_q  <= len_q;
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        acc_q   <= '0;
                        len_q   <= '0;
                        first_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.res_valid = res_valid_c;
    assign bus.res_data  = res_data_q;
    assign bus.res_len   = res_len_q;
endmodule

// File: tb/tb_chk_sum_stream.sv
// Directed bench for chk_sum_stream: three engines (raw, inverted, inverted
// with zero fix) share one stimulus stream and are checked against
// hand-computed sums.
module tb_chk_sum_stream;
    logic        clk;
    logic        rst;
    logic [15:0] seed;
    logic        abort;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_keep;
    logic        in_last;
    logic        res_ready;

    int n_checks = 0;
    int n_fail   = 0;

    chk_sum_stream_if #(.DATA_W(32), .LEN_W(16)) if_raw ();
    chk_sum_stream_if #(.DATA_W(32), .LEN_W(16)) if_inv ();
    chk_sum_stream_if #(.DATA_W(32), .LEN_W(16)) if_zf ();

    assign if_raw.in_valid  = in_valid;
    assign if_raw.in_data   = in_data;
    assign if_raw.in_keep   = in_keep;
    assign if_raw.in_last   = in_last;
    assign if_raw.res_ready = res_ready;
    assign if_inv.in_valid  = in_valid;
    assign if_inv.in_data   = in_data;
    assign if_inv.in_keep   = in_keep;
    assign if_inv.in_last   = in_last;
    assign if_inv.res_ready = res_ready;
    assign if_zf.in_valid   = in_valid;
    assign if_zf.in_data    = in_data;
    assign if_zf.in_keep    = in_keep;
    assign if_zf.in_last    = in_last;
    assign if_zf.res_ready  = res_ready;

    chk_sum_stream #(.DATA_W(32), .LEN_W(16), .INVERT(1'b0), .ZERO_FIX(1'b0)) u_raw (
        .clk(clk), .rst(rst), .seed(seed), .abort(abort), .bus(if_raw));
    chk_sum_stream #(.DATA_W(32), .LEN_W(16), .INVERT(1'b1), .ZERO_FIX(1'b0)) u_inv (
        .clk(clk), .rst(rst), .seed(seed), .abort(abort), .bus(if_inv));
    chk_sum_stream #(.DATA_W(32), .LEN_W(16), .INVERT(1'b1), .ZERO_FIX(1'b1)) u_zf (
        .clk(clk), .rst(rst), .seed(seed), .abort(abort), .bus(if_zf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the edge that accepts it.
    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        n = 0;
        while (!if_raw.in_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("beat_ready_timeout", 32'(if_raw.in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        in_keep  = '0;
    endtask

    // Called just after the last-beat edge: check FIN cycle, result, optional
    // backpressure hold, then complete the handshake.
    task automatic get_result(input string tag, input logic [15:0] exp_raw,
                              input logic [15:0] exp_len, input int hold);
        logic [15:0] exp_inv;
        logic [15:0] exp_zf;
        exp_inv = ~exp_raw;
        exp_zf  = (exp_inv == 16'h0000) ? 16'hFFFF : exp_inv;
        check({tag, "_fin_valid"}, 32'(if_raw.res_valid), 32'd0);
        check({tag, "_fin_ready"}, 32'(if_raw.in_ready), 32'd0);
        step();
        check({tag, "_valid"}, 32'(if_raw.res_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_keep  = 4'hF;
            check({tag, "_hold_ready"}, 32'(if_inv.in_ready), 32'd0);
            check({tag, "_hold_valid"}, 32'(if_inv.res_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(if_inv.res_data), 32'(exp_inv));
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
        in_keep  = '0;
        check({tag, "_raw"}, 32'(if_raw.res_data), 32'(exp_raw));
        check({tag, "_inv"}, 32'(if_inv.res_data), 32'(exp_inv));
        check({tag, "_zf"},  32'(if_zf.res_data),  32'(exp_zf));
        check({tag, "_len"}, 32'(if_raw.res_len),  32'(exp_len));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({tag, "_done_ready"}, 32'(if_raw.in_ready), 32'd1);
        check({tag, "_done_valid"}, 32'(if_raw.res_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        seed      = '0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_keep   = '0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state.
        check("rst_in_ready",  32'(if_raw.in_ready),  32'd1);
        check("rst_res_valid", 32'(if_raw.res_valid), 32'd0);
        check("rst_res_data",  32'(if_inv.res_data),  32'd0);
        check("rst_res_len",   32'(if_raw.res_len),   32'd0);

        // IPv4 header: inverted checksum 0xB861, folded raw sum 0x479E.
        beat(32'h4500_0073, 4'hF, 1'b0);
        beat(32'h0000_4000, 4'hF, 1'b0);
        beat(32'h4011_0000, 4'hF, 1'b0);
        beat(32'hC0A8_0001, 4'hF, 1'b0);
        beat(32'hC0A8_00C7, 4'hF, 1'b1);
        get_result("ipv4", 16'h479E, 16'd20, 0);
        check("ipv4_b861", 32'(if_inv.res_data), 32'h0000_B861);

        // Odd length: lanes 0..2 kept -> 0x1234 + 0x5600.
        beat(32'h1234_5678, 4'b0111, 1'b1);
        get_result("odd", 16'h6834, 16'd3, 0);

        // Sparse keep: lanes 1 and 3 kept -> 0x00BB + 0x00DD.
        beat(32'hAABB_CCDD, 4'b1010, 1'b1);
        get_result("sparse", 16'h0198, 16'd2, 0);

        // End-around carry; seed changed on the second beat must be ignored.
        seed = 16'h0000;
        beat(32'hFFFF_FFFF, 4'hF, 1'b0);
        seed = 16'h1234;
        beat(32'h0001_0000, 4'hF, 1'b1);
        seed = 16'h0000;
        get_result("carry", 16'h0001, 16'd8, 0);

        // Zero rule: raw 0xFFFF inverts to 0x0000 (0xFFFF with zero fix).
        beat(32'hFFFF_0000, 4'hF, 1'b1);
        get_result("zero", 16'hFFFF, 16'd4, 0);

        // Seed plus 10 cycles of result backpressure with in_valid driven.
        seed = 16'h0011;
        beat(32'h1000_0000, 4'hF, 1'b1);
        seed = 16'h0000;
        get_result("seed_bp", 16'h1011, 16'd4, 10);
        beat(32'h0001_0000, 4'hF, 1'b1);
        get_result("seed_clear", 16'h0001, 16'd4, 0);

        // Abort after two beats, then a clean packet.
        beat(32'h1111_1111, 4'hF, 1'b0);
        beat(32'h2222_2222, 4'hF, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        beat(32'h0002_0000, 4'hF, 1'b1);
        get_result("abort_mid", 16'h0002, 16'd4, 0);

        // Abort coincident with a last-beat accept: no result ever appears.
        in_valid = 1'b1;
        in_data  = 32'h0005_0000;
        in_keep  = 4'hF;
        in_last  = 1'b1;
        abort    = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("abort_last_ready", 32'(if_raw.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("abort_last_valid", 32'(if_raw.res_valid), 32'd0);
            step();
        end
        // First-beat flag restored: seed applies to the next packet.
        seed = 16'h0010;
        beat(32'h0003_0000, 4'hF, 1'b1);
        seed = 16'h0000;
        get_result("abort_last_next", 16'h0013, 16'd4, 0);

        // Abort while a result is pending clears the output registers.
        beat(32'h0007_0000, 4'hF, 1'b1);
        step();
        check("abort_out_pre", 32'(if_raw.res_valid), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_out_valid", 32'(if_raw.res_valid), 32'd0);
        check("abort_out_ready", 32'(if_raw.in_ready),  32'd1);
        check("abort_out_data",  32'(if_raw.res_data),  32'd0);
        check("abort_out_len",   32'(if_raw.res_len),   32'd0);

        // Reset while a result is pending.
        beat(32'h0008_0000, 4'hF, 1'b1);
        step();
        check("rst_out_pre", 32'(if_raw.res_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_out_valid", 32'(if_raw.res_valid), 32'd0);
        check("rst_out_ready", 32'(if_raw.in_ready),  32'd1);
        check("rst_out_data",  32'(if_inv.res_data),  32'd0);
        beat(32'h0009_0000, 4'hF, 1'b1);
        get_result("rst_next", 16'h0009, 16'd4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
